slot_spin_controller: RTL and testbench

Sequences one three-reel spin of the slot game. Takes raw START and STOP pushbuttons, charges a bet, and runs a free-running 4-bit reel counter. On each stop event it captures that counter into reels 0, 1 and 2 in order, then evaluates the match class. Sits between the board keys and credit bank on one side and the hex/VGA display path on the other.

---
 rtl/slot_pkg.sv | 20 ++
 rtl/slot_spin_controller_if.sv | 25 ++
 rtl/slot_spin_controller_key_debounce.sv | 48 ++++
 rtl/slot_spin_controller.sv | 165 ++++++++++++++++
 tb/tb_slot_spin_controller.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot spin controller.
package slot_pkg;

  localparam int REEL_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SPIN0,
    SPIN1,
    SPIN2,
    EVAL
  } state_t;

  typedef logic [1:0] match_t;

  localparam match_t MATCH_NONE   = 2'b00;
  localparam match_t MATCH_PAIR   = 2'b01;
  localparam match_t MATCH_TRIPLE = 2'b10;

endpackage

// File: rtl/slot_spin_controller_if.sv
// Bet / result bus between the spin controller and the credit bank / display path.
interface slot_spin_controller_if #(
  parameter int REEL_W = 4
);

  logic                  bet_ok;
  logic                  bet_take;
  logic [REEL_W-1:0]     spin_value;
  logic [2:0]            reel_live;
  logic [3*REEL_W-1:0]   reel_value;
  logic                  result_valid;
  logic [1:0]            match;
  logic                  busy;

  modport master (
    input  bet_ok,
    output bet_take, spin_value, reel_live, reel_value, result_valid, match, busy
  );

  modport slave (
    output bet_ok,
    input  bet_take, spin_value, reel_live, reel_value, result_valid, match, busy
  );

endinterface

// File: rtl/slot_spin_controller_key_debounce.sv
// Raw active-low key -> 2-FF synchronizer -> debounced level -> one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchronize, then accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/slot_spin_controller.sv
// Three-reel spin sequencer: bet charge, free-running reel counter, per-reel capture, match evaluation.
// Optional feature: define SLOT_AUTOSTOP_EN to force-stop a reel after AUTOSTOP_CYCLES cycles.
module slot_spin_controller
  import slot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTOSTOP_CYCLES = 250000000,
  parameter int REEL_W          = REEL_W_DEF
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start_key_n,
  input  logic                    stop_key_n,
  slot_spin_controller_if.master  bus
);

  state_t                r_state;
  logic                  r_bet_take;
  logic [REEL_W-1:0]     r_spin_value;
  logic [2:0]            r_reel_live;
  logic [3*REEL_W-1:0]   r_reel_value;
  logic                  r_result_valid;
  match_t                r_match;
  logic                  r_busy;

  logic                  w_start_evt;
  logic                  w_stop_evt;
  logic                  w_timeout;
  logic                  w_spinning;
  logic                  w_stop_any;
  logic [REEL_W-1:0]     w_r0;
  logic [REEL_W-1:0]     w_r1;
  logic [REEL_W-1:0]     w_r2;
  match_t                w_match;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_key_n  (start_key_n),
    .o_press  (w_start_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_key (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_key_n  (stop_key_n),
    .o_press  (w_stop_evt)
  );

  assign w_spinning = (r_state == SPIN0) || (r_state == SPIN1) || (r_state == SPIN2);
  assign w_stop_any = w_stop_evt || w_timeout;

`ifdef SLOT_AUTOSTOP_EN
  localparam int TIMER_W = (AUTOSTOP_CYCLES > 1) ? $clog2(AUTOSTOP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTOSTOP_CYCLES - 1);

  logic [TIMER_W-1:0] r_timer;

  // Per-reel spin timer: cleared outside SPIN and on every capture, saturates at all-ones.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_timer <= '0;
    end else if (!w_spinning || w_stop_any) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = w_spinning && (r_timer == TIMER_LAST);
`else
  // AUTOSTOP_CYCLES has no effect in this build.
  logic w_unused_autostop;
  assign w_unused_autostop = (AUTOSTOP_CYCLES == 0);
  assign w_timeout         = 1'b0;
`endif

  // Free-running down counter that animates live reels and supplies captured symbols.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_spin_value <= '1;
    end else begin
      r_spin_value <= r_spin_value - 1'b1;
    end
  end

  assign w_r0 = r_reel_value[2*REEL_W +: REEL_W];
  assign w_r1 = r_reel_value[REEL_W   +: REEL_W];
  assign w_r2 = r_reel_value[0        +: REEL_W];

  // Match class of the three captured reels.
  always_comb begin
    w_match = MATCH_NONE;
    if ((w_r0 == w_r1) && (w_r1 == w_r2)) begin
      w_match = MATCH_TRIPLE;
    end else if ((w_r0 == w_r1) || (w_r1 == w_r2) || (w_r0 == w_r2)) begin
      w_match = MATCH_PAIR;
    end
  end

  // Spin sequencer with registered outputs; start wins in IDLE, stop wins while spinning.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state        <= IDLE;
      r_bet_take     <= 1'b0;
      r_reel_live    <= '0;
      r_reel_value   <= '0;
      r_result_valid <= 1'b0;
      r_match        <= MATCH_NONE;
      r_busy         <= 1'b0;
    end else begin
      r_bet_take     <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_evt && bus.bet_ok) begin
            r_bet_take   <= 1'b1;
            r_reel_live  <= 3'b111;
            r_reel_value <= '0;
            r_match      <= MATCH_NONE;
            r_busy       <= 1'b1;
            r_state      <= SPIN0;
          end
        end
        SPIN0: begin
          if (w_stop_any) begin
            r_reel_value[2*REEL_W +: REEL_W] <= r_spin_value;
            r_reel_live[0]                   <= 1'b0;
            r_state                          <= SPIN1;
          end
        end
        SPIN1: begin
          if (w_stop_any) begin
            r_reel_value[REEL_W +: REEL_W] <= r_spin_value;
            r_reel_live[1]                 <= 1'b0;
            r_state                        <= SPIN2;
          end
        end
        SPIN2: begin
          if (w_stop_any) begin
            r_reel_value[0 +: REEL_W] <= r_spin_value;
            r_reel_live[2]            <= 1'b0;
            r_state                   <= EVAL;
          end
        end
        EVAL: begin
          r_match        <= w_match;
          r_result_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bet_take     = r_bet_take;
  assign bus.spin_value   = r_spin_value;
  assign bus.reel_live    = r_reel_live;
  assign bus.reel_value   = r_reel_value;
  assign bus.result_valid = r_result_valid;
  assign bus.match        = r_match;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_slot_spin_controller.sv
// Directed bench for slot_spin_controller (DEBOUNCE_CYCLES=4, AUTOSTOP_CYCLES=20).
// Build with SLOT_AUTOSTOP_EN defined to exercise the autostop path instead of the long-spin path.
module tb_slot_spin_controller;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic start_key_n;
  logic stop_key_n;

  slot_spin_controller_if #(.REEL_W(4)) bus ();

  slot_spin_controller #(
    .DEBOUNCE_CYCLES (4),
    .AUTOSTOP_CYCLES (20),
    .REEL_W          (4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start_key_n (start_key_n),
    .stop_key_n  (stop_key_n),
    .bus         (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model of the free-running counter and a cycle index.
  logic [3:0]  m_spin;
  int unsigned cyc = 0;
  always @(posedge CLOCK_50) begin
    if (reset) m_spin <= 4'hF;
    else       m_spin <= m_spin - 4'd1;
    cyc <= cyc + 1;
  end

  // Pulse monitors sampled mid-cycle.
  int          n_bet   = 0;
  int          n_rv    = 0;
  int unsigned rv_cyc  = 0;
  int unsigned cap_cyc = 0;
  logic [1:0]  rv_match = 2'b00;
  logic        rv_busy  = 1'b0;
  logic [2:0]  prev_live = 3'b000;
  always @(negedge CLOCK_50) begin
    if (bus.bet_take) n_bet++;
    if (bus.result_valid) begin
      n_rv++;
      rv_cyc   = cyc;
      rv_match = bus.match;
      rv_busy  = bus.busy;
    end
    if (prev_live != 3'b000 && bus.reel_live == 3'b000) cap_cyc = cyc;
    prev_live = bus.reel_live;
  end

  typedef struct {
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [11:0] exp_reels;
    logic [1:0]  exp_match;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press START long enough to debounce, then release and let the release settle.
  task automatic press_start();
    start_key_n = 1'b0;
    ticks(10);
    start_key_n = 1'b1;
    ticks(8);
  endtask

  // Press STOP so that the press event (2 sync + 4 debounce cycles later) sees spin_value == target.
  task automatic press_stop(input logic [3:0] target);
    int guard = 0;
    while (m_spin != (target + 4'd6) && guard < 16) begin
      tick();
      guard++;
    end
    stop_key_n = 1'b0;
    ticks(8);
    stop_key_n = 1'b1;
    ticks(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bet_take"},     bus.bet_take,     0);
    check({tag, "_spin_value"},   bus.spin_value,   4'hF);
    check({tag, "_reel_live"},    bus.reel_live,    0);
    check({tag, "_reel_value"},   bus.reel_value,   0);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_match"},        bus.match,        0);
    check({tag, "_busy"},         bus.busy,         0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int nb0;
    int nr0;
    int guard;
    logic [3:0] exp_sym;

    vecs[0] = '{4'h7, 4'h7, 4'h7, 12'h777, 2'b10};
    vecs[1] = '{4'h7, 4'h7, 4'h3, 12'h773, 2'b01};
    vecs[2] = '{4'h1, 4'h2, 4'h3, 12'h123, 2'b00};
    vecs[3] = '{4'h7, 4'h3, 4'h7, 12'h737, 2'b01};
    vecs[4] = '{4'h3, 4'h7, 4'h7, 12'h377, 2'b01};
    vecs[5] = '{4'hF, 4'h0, 4'hF, 12'hF0F, 2'b01};
    vecs[6] = '{4'h0, 4'h0, 4'h0, 12'h000, 2'b10};

    reset       = 1'b1;
    start_key_n = 1'b1;
    stop_key_n  = 1'b1;
    bus.bet_ok  = 1'b1;
    ticks(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check("spin_after_reset", bus.spin_value, 4'hE);

    // START without credit is ignored; STOP in IDLE is ignored.
    bus.bet_ok = 1'b0;
    nb0 = n_bet;
    nr0 = n_rv;
    press_start();
    check("nocredit_bet_take", n_bet - nb0, 0);
    check("nocredit_busy",     bus.busy,      0);
    check("nocredit_live",     bus.reel_live, 0);
    bus.bet_ok = 1'b1;
    press_stop(4'h9);
    check("idle_stop_reels", bus.reel_value, 0);
    check("idle_stop_live",  bus.reel_live,  0);
    check("idle_stop_rv",    n_rv - nr0,     0);

`ifndef SLOT_AUTOSTOP_EN
    for (int i = 0; i < NV; i++) begin
      nb0 = n_bet;
      nr0 = n_rv;
      press_start();
      check("start_bet_take", n_bet - nb0,    1);
      check("start_live",     bus.reel_live,  3'b111);
      check("start_busy",     bus.busy,       1);
      check("start_reels",    bus.reel_value, 0);
      check("start_match",    bus.match,      0);
      check("spin_value",     bus.spin_value, m_spin);
      press_stop(vecs[i].r0);
      check("stop0_live",  bus.reel_live,  3'b110);
      check("stop0_reels", bus.reel_value, {vecs[i].r0, 8'h00});
      press_stop(vecs[i].r1);
      check("stop1_live",  bus.reel_live,  3'b100);
      check("stop1_reels", bus.reel_value, {vecs[i].r0, vecs[i].r1, 4'h0});
      press_stop(vecs[i].r2);
      check("res_pulses",  n_rv - nr0,        1);
      check("res_latency", rv_cyc - cap_cyc,  1);
      check("res_match",   rv_match,          vecs[i].exp_match);
      check("res_busy",    rv_busy,           0);
      check("res_reels",   bus.reel_value,    vecs[i].exp_reels);
      check("res_live",    bus.reel_live,     0);
      check("res_hold",    bus.match,         vecs[i].exp_match);
    end

    // Long spin without autostop, then bounce and START during SPIN1.
    nb0 = n_bet;
    press_start();
    check("long_bet_take", n_bet - nb0, 1);
    ticks(1000);
    check("long_live",  bus.reel_live,  3'b111);
    check("long_reels", bus.reel_value, 0);
    press_stop(4'h5);
    check("long_stop0_live",  bus.reel_live,  3'b110);
    check("long_stop0_reels", bus.reel_value, 12'h500);
    stop_key_n = 1'b0;
    ticks(3);
    stop_key_n = 1'b1;
    ticks(10);
    check("bounce_live",  bus.reel_live,  3'b110);
    check("bounce_reels", bus.reel_value, 12'h500);
    start_key_n = 1'b0;
    ticks(10);
    start_key_n = 1'b1;
    ticks(8);
    check("spin1_start_bet", n_bet - nb0,   1);
    check("spin1_start_live", bus.reel_live, 3'b110);
    check("spin1_start_busy", bus.busy,      1);
`else
    // Reel 0 left alone is forced to stop 20 cycles after entering SPIN0.
    nb0 = n_bet;
    start_key_n = 1'b0;
    guard = 0;
    while (!bus.busy && guard < 20) begin
      tick();
      guard++;
    end
    start_key_n = 1'b1;
    check("auto_enter_busy", bus.busy,    1);
    check("auto_bet_take",   n_bet - nb0, 1);
    ticks(19);
    check("auto_pre_live", bus.reel_live, 3'b111);
    exp_sym = m_spin;
    tick();
    check("auto_live",  bus.reel_live,  3'b110);
    check("auto_reels", bus.reel_value, {exp_sym, 8'h00});
`endif

    // Reset in SPIN1: everything returns to reset values, a later STOP captures nothing.
    nb0 = n_bet;
    nr0 = n_rv;
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    press_stop(4'h2);
    check("post_reset_live",  bus.reel_live,  0);
    check("post_reset_reels", bus.reel_value, 0);
    check("post_reset_busy",  bus.busy,       0);
    check("post_reset_bet",   n_bet - nb0,    0);
    check("post_reset_rv",    n_rv - nr0,     0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
